// File: rtl/jpeg_sched_pkg.sv
// Shared types and encodings for the JPEG MCU scheduler.
// The MARKER state exists only when JPEG_SCHED_RESTART_EN is defined.
package jpeg_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_MCU  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_RUN       = 3'd3,
        ST_NEXT      = 3'd4,
`ifdef JPEG_SCHED_RESTART_EN
        ST_MARKER    = 3'd5,
`endif
        ST_FRAME_END = 3'd6
    } sched_state_e;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam logic QTAB_LUMA   = 1'b0;
    localparam logic QTAB_CHROMA = 1'b1;

    // Last block of the MCU is Cr, the one before it Cb, everything earlier Y.
    function automatic logic [1:0] comp_of(input logic [2:0] blk, input logic [2:0] last_blk);
        if (blk == last_blk) begin
            return COMP_CR;
        end else if (blk == last_blk - 3'd1) begin
            return COMP_CB;
        end
        return COMP_Y;
    endfunction

endpackage

// File: rtl/jpeg_rst_counter.sv
// Restart-interval bookkeeping: MCUs since last marker, due flag, RSTn index.
// Instantiated by jpeg_mcu_scheduler only under JPEG_SCHED_RESTART_EN.
module jpeg_rst_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_ack,
    input  logic [CNT_W-1:0] i_interval,
    output logic             o_due_c,
    output logic [2:0]       o_idx
);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;

    // Counter includes the MCU currently in flight, since it counts on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (i_ack) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_due_c = (i_interval != '0) && (r_cnt == i_interval);
    assign o_idx   = r_idx;

endmodule

// File: rtl/jpeg_mcu_scheduler.sv
// Issues one datapath start per 8x8 block of each MCU and counts MCUs per frame.
// Restart-marker support is compiled in with JPEG_SCHED_RESTART_EN.
module jpeg_mcu_scheduler
    import jpeg_sched_pkg::*;
#(
    parameter int unsigned MCU_BLOCKS = 6,
    parameter int unsigned MCU_CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_frame_start,
    input  logic [MCU_CNT_W-1:0] i_frame_mcus,
    input  logic                 i_mcu_valid,
    output logic                 o_mcu_ready,
    input  logic                 i_ent_ready,
    output logic                 o_dp_start,
    output logic [2:0]           o_dp_blk_idx,
    output logic [1:0]           o_dp_comp,
    output logic                 o_dp_qtab_sel,
    input  logic                 i_dp_done,
    output logic                 o_dc_pred_clr,
    output logic                 o_frame_done,
    output logic                 o_busy
`ifdef JPEG_SCHED_RESTART_EN
    ,
    input  logic [MCU_CNT_W-1:0] i_rst_interval,
    output logic                 o_rst_marker_req,
    input  logic                 i_rst_marker_ack,
    output logic [2:0]           o_rst_marker_idx
`endif
);

    localparam logic [2:0] LAST_BLK = 3'(MCU_BLOCKS - 1);

    sched_state_e         r_state;
    sched_state_e         w_state_nxt;
    logic [MCU_CNT_W-1:0] r_mcu_cnt;
    logic [2:0]           r_blk_idx;
    logic [2:0]           w_blk_nxt;
    logic [1:0]           r_comp;
    logic [1:0]           w_comp_nxt;
    logic                 r_qtab;
    logic                 r_dc_clr;
    logic                 w_frame_go;
    logic                 w_mcu_take;
    logic                 w_in_blk;

`ifdef JPEG_SCHED_RESTART_EN
    logic w_rst_due;
    logic w_marker_ack;

    jpeg_rst_counter #(
        .CNT_W (MCU_CNT_W)
    ) u_rst_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_frame_go),
        .i_inc      (w_mcu_take),
        .i_ack      (w_marker_ack),
        .i_interval (i_rst_interval),
        .o_due_c    (w_rst_due),
        .o_idx      (o_rst_marker_idx)
    );
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_blk_nxt    = r_blk_idx;
        w_frame_go   = 1'b0;
        w_mcu_take   = 1'b0;
        o_mcu_ready  = 1'b0;
        o_dp_start   = 1'b0;
        o_frame_done = 1'b0;
        o_busy       = (r_state != ST_IDLE);
`ifdef JPEG_SCHED_RESTART_EN
        w_marker_ack     = 1'b0;
        o_rst_marker_req = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_frame_start) begin
                    w_frame_go  = 1'b1;
                    w_state_nxt = (i_frame_mcus == '0) ? ST_FRAME_END : ST_WAIT_MCU;
                end
            end
            ST_WAIT_MCU: begin
                o_mcu_ready = 1'b1;
                if (i_mcu_valid) begin
                    w_mcu_take  = 1'b1;
                    w_blk_nxt   = 3'd0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_dp_start = i_ent_ready;
                if (i_ent_ready) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_dp_done) begin
                    if (r_blk_idx == LAST_BLK) begin
                        w_state_nxt = ST_NEXT;
                    end else begin
                        w_blk_nxt   = r_blk_idx + 3'd1;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_NEXT: begin
                // Counter still holds the pre-decrement value here.
                if (r_mcu_cnt <= MCU_CNT_W'(1)) begin
                    w_state_nxt = ST_FRAME_END;
`ifdef JPEG_SCHED_RESTART_EN
                end else if (w_rst_due) begin
                    w_state_nxt = ST_MARKER;
`endif
                end else begin
                    w_state_nxt = ST_WAIT_MCU;
                end
            end
`ifdef JPEG_SCHED_RESTART_EN
            ST_MARKER: begin
                o_rst_marker_req = 1'b1;
                if (i_rst_marker_ack) begin
                    w_marker_ack = 1'b1;
                    w_state_nxt  = ST_WAIT_MCU;
                end
            end
`endif
            ST_FRAME_END: begin
                o_frame_done = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_in_blk   = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_RUN);
    assign w_comp_nxt = comp_of(w_blk_nxt, LAST_BLK);

    // Block selects are loaded on entry to ISSUE and zeroed whenever the block is not active.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mcu_cnt <= '0;
            r_blk_idx <= '0;
            r_comp    <= COMP_Y;
            r_qtab    <= QTAB_LUMA;
            r_dc_clr  <= 1'b0;
        end else begin
            if (w_frame_go) begin
                r_mcu_cnt <= i_frame_mcus;
            end else if ((r_state == ST_NEXT) && (r_mcu_cnt != '0)) begin
                r_mcu_cnt <= r_mcu_cnt - MCU_CNT_W'(1);
            end
`ifdef JPEG_SCHED_RESTART_EN
            r_dc_clr <= w_frame_go | w_marker_ack;
`else
            r_dc_clr <= w_frame_go;
`endif
            if (w_in_blk) begin
                r_blk_idx <= w_blk_nxt;
                r_comp    <= w_comp_nxt;
                r_qtab    <= (w_comp_nxt != COMP_Y) ? QTAB_CHROMA : QTAB_LUMA;
            end else begin
                r_blk_idx <= '0;
                r_comp    <= COMP_Y;
                r_qtab    <= QTAB_LUMA;
            end
        end
    end

    assign o_dp_blk_idx  = r_blk_idx;
    assign o_dp_comp     = r_comp;
    assign o_dp_qtab_sel = r_qtab;
    assign o_dc_pred_clr = r_dc_clr;

endmodule

// File: tb/tb_jpeg_mcu_scheduler.sv
// Directed testbench for jpeg_mcu_scheduler (MCU_BLOCKS = 6, 4:2:0).
// Restart-marker scenario runs only when JPEG_SCHED_RESTART_EN is defined.
module tb_jpeg_mcu_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] frame_mcus = '0;
    logic        mcu_valid = 1'b0;
    logic        ent_ready = 1'b1;
    logic        dp_done = 1'b0;
    logic        mcu_ready, dp_start, dp_qtab_sel, dc_pred_clr, frame_done, busy;
    logic [2:0]  dp_blk_idx;
    logic [1:0]  dp_comp;
`ifdef JPEG_SCHED_RESTART_EN
    logic [15:0] rst_interval = '0;
    logic        rst_marker_ack = 1'b0;
    logic        rst_marker_req;
    logic [2:0]  rst_marker_idx;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    jpeg_mcu_scheduler #(.MCU_BLOCKS(6), .MCU_CNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_start (frame_start),
        .i_frame_mcus  (frame_mcus),
        .i_mcu_valid   (mcu_valid),
        .o_mcu_ready   (mcu_ready),
        .i_ent_ready   (ent_ready),
        .o_dp_start    (dp_start),
        .o_dp_blk_idx  (dp_blk_idx),
        .o_dp_comp     (dp_comp),
        .o_dp_qtab_sel (dp_qtab_sel),
        .i_dp_done     (dp_done),
        .o_dc_pred_clr (dc_pred_clr),
        .o_frame_done  (frame_done),
        .o_busy        (busy)
`ifdef JPEG_SCHED_RESTART_EN
        ,
        .i_rst_interval   (rst_interval),
        .o_rst_marker_req (rst_marker_req),
        .i_rst_marker_ack (rst_marker_ack),
        .o_rst_marker_idx (rst_marker_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] outs();
        return {mcu_ready, dp_start, dp_blk_idx, dp_comp, dp_qtab_sel, dc_pred_clr, frame_done, busy};
    endfunction

    // Stimulus only: walks nb blocks with 1-cycle datapath latency from an ISSUE cycle.
    task automatic drive_blocks(input int nb, output int starts);
        starts = 0;
        for (int i = 0; i < nb; i++) begin
            if (dp_start === 1'b1) starts++;
            tick;
            dp_done = 1'b1;
            tick;
            dp_done = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        n_tests++;
        if (outs() !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", outs(), 11'd0);
        end
        rst = 1'b0;
        tick;
        n_tests++;
        if (outs() !== 11'd0) begin
            n_fail++; $display("FAIL idle_outputs: got %b expected %b", outs(), 11'd0);
        end
    endtask

    task automatic test_nominal;
        logic [1:0] exp_c [6];
        int cd, n_start, n_done, n_fd, n_clr, last_done, fd_cyc, first_start, k;
        exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        cd = 0; n_start = 0; n_done = 0; n_fd = 0; n_clr = 0;
        last_done = -1; fd_cyc = -100; first_start = -1;
        frame_mcus = 16'd2; mcu_valid = 1'b1; ent_ready = 1'b1;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n_tests++;
        if (mcu_ready !== 1'b1) begin
            n_fail++; $display("FAIL nominal_ready_latency: got %b expected 1", mcu_ready);
        end
        for (int cyc = 0; cyc < 70; cyc++) begin
            dp_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin dp_done = 1'b1; n_done++; last_done = cyc; end
            end
            if (dp_start === 1'b1) begin
                k = n_start % 6;
                if (first_start < 0) first_start = cyc;
                n_tests++;
                if (dp_comp !== exp_c[k] || dp_qtab_sel !== (k >= 4) || dp_blk_idx !== 3'(k)) begin
                    n_fail++;
                    $display("FAIL nominal_block%0d: got idx=%0d comp=%0d q=%0d expected idx=%0d comp=%0d q=%0d",
                             n_start, dp_blk_idx, dp_comp, dp_qtab_sel, k, exp_c[k], (k >= 4));
                end
                n_start++;
                cd = 3;
            end
            if (dc_pred_clr === 1'b1) n_clr++;
            if (frame_done === 1'b1) begin n_fd++; fd_cyc = cyc; end
            tick;
        end
        dp_done = 1'b0; mcu_valid = 1'b0;
        n_tests++;
        if (first_start !== 1) begin
            n_fail++; $display("FAIL nominal_first_start: got cycle %0d expected 1", first_start);
        end
        n_tests++;
        if (n_start !== 12) begin
            n_fail++; $display("FAIL nominal_starts: got %0d expected 12", n_start);
        end
        n_tests++;
        if (n_fd !== 1) begin
            n_fail++; $display("FAIL nominal_frame_done_count: got %0d expected 1", n_fd);
        end
        n_tests++;
        if (fd_cyc !== last_done + 2) begin
            n_fail++; $display("FAIL nominal_frame_done_time: got %0d expected %0d", fd_cyc, last_done + 2);
        end
        n_tests++;
        if (n_clr !== 1) begin
            n_fail++; $display("FAIL nominal_dc_clr: got %0d expected 1", n_clr);
        end
    endtask

    task automatic test_backpressure;
        frame_mcus = 16'd1; mcu_valid = 1'b1; ent_ready = 1'b1;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        mcu_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            n_tests++;
            if (dp_start !== 1'b1 || dp_blk_idx !== 3'(b)) begin
                n_fail++; $display("FAIL bp_issue%0d: got start=%b idx=%0d expected start=1 idx=%0d", b, dp_start, dp_blk_idx, b);
            end
            tick;
            dp_done = 1'b1;
            if (b == 3) ent_ready = 1'b0;
            tick;
            dp_done = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({dp_start, dp_blk_idx, dp_comp, dp_qtab_sel} !== {1'b0, 3'd4, 2'd1, 1'b1}) begin
                n_fail++; $display("FAIL bp_stall%0d: got start=%b idx=%0d comp=%0d q=%b expected start=0 idx=4 comp=1 q=1",
                                   i, dp_start, dp_blk_idx, dp_comp, dp_qtab_sel);
            end
            tick;
        end
        ent_ready = 1'b1;
        #1;
        n_tests++;
        if (dp_start !== 1'b1 || dp_blk_idx !== 3'd4) begin
            n_fail++; $display("FAIL bp_release: got start=%b idx=%0d expected start=1 idx=4", dp_start, dp_blk_idx);
        end
        tick;
        dp_done = 1'b1;
        tick;
        dp_done = 1'b0;
        n_tests++;
        if (dp_start !== 1'b1 || dp_comp !== 2'd2 || dp_qtab_sel !== 1'b1) begin
            n_fail++; $display("FAIL bp_cr_block: got start=%b comp=%0d q=%b expected start=1 comp=2 q=1", dp_start, dp_comp, dp_qtab_sel);
        end
        tick;
        dp_done = 1'b1;
        tick;
        dp_done = 1'b0;
        n_tests++;
        if (frame_done !== 1'b0 || dp_blk_idx !== 3'd0 || dp_comp !== 2'd0) begin
            n_fail++; $display("FAIL bp_next_state: got fd=%b idx=%0d comp=%0d expected fd=0 idx=0 comp=0", frame_done, dp_blk_idx, dp_comp);
        end
        tick;
        n_tests++;
        if (frame_done !== 1'b1) begin
            n_fail++; $display("FAIL bp_frame_done: got %b expected 1", frame_done);
        end
        tick;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_empty;
        frame_mcus = 16'd0; mcu_valid = 1'b1;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        n_tests++;
        if ({frame_done, dc_pred_clr, mcu_ready, dp_start, busy} !== 5'b11001) begin
            n_fail++; $display("FAIL empty_end: got fd,clr,rdy,start,busy=%b expected 11001", {frame_done, dc_pred_clr, mcu_ready, dp_start, busy});
        end
        tick;
        n_tests++;
        if (outs() !== 11'd0) begin
            n_fail++; $display("FAIL empty_idle: got %b expected %b", outs(), 11'd0);
        end
        tick;
        mcu_valid = 1'b0;
        n_tests++;
        if (outs() !== 11'd0) begin
            n_fail++; $display("FAIL empty_quiet: got %b expected %b", outs(), 11'd0);
        end
    endtask

    task automatic test_spurious;
        int s;
        frame_mcus = 16'd1; mcu_valid = 1'b0; ent_ready = 1'b1;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        dp_done = 1'b1;
        tick;
        dp_done = 1'b0;
        n_tests++;
        if ({mcu_ready, dp_start, dc_pred_clr, frame_done, busy, dp_blk_idx} !== {5'b10001, 3'd0}) begin
            n_fail++; $display("FAIL spurious_done_wait: got %b expected %b",
                               {mcu_ready, dp_start, dc_pred_clr, frame_done, busy, dp_blk_idx}, {5'b10001, 3'd0});
        end
        mcu_valid = 1'b1;
        tick;
        mcu_valid = 1'b0;
        tick;
        frame_start = 1'b1; frame_mcus = 16'd0;
        tick;
        frame_start = 1'b0;
        n_tests++;
        if ({mcu_ready, dp_start, dc_pred_clr, frame_done, busy, dp_blk_idx} !== {5'b00001, 3'd0}) begin
            n_fail++; $display("FAIL spurious_start_run: got %b expected %b",
                               {mcu_ready, dp_start, dc_pred_clr, frame_done, busy, dp_blk_idx}, {5'b00001, 3'd0});
        end
        dp_done = 1'b1;
        tick;
        dp_done = 1'b0;
        drive_blocks(5, s);
        n_tests++;
        if (s !== 5) begin
            n_fail++; $display("FAIL spurious_remaining_starts: got %0d expected 5", s);
        end
        tick;
        n_tests++;
        if (frame_done !== 1'b1) begin
            n_fail++; $display("FAIL spurious_frame_done: got %b expected 1", frame_done);
        end
        tick;
    endtask

    task automatic test_reset_mid_block;
        int s;
        frame_mcus = 16'd1; mcu_valid = 1'b1; ent_ready = 1'b1;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        mcu_valid = 1'b0;
        drive_blocks(3, s);
        tick;
        n_tests++;
        if (dp_blk_idx !== 3'd3 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got idx=%0d busy=%b expected idx=3 busy=1", dp_blk_idx, busy);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        dp_done = 1'b1;
        n_tests++;
        if (outs() !== 11'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b expected %b", outs(), 11'd0);
        end
        tick;
        dp_done = 1'b0;
        n_tests++;
        if (outs() !== 11'd0) begin
            n_fail++; $display("FAIL midrst_late_done: got %b expected %b", outs(), 11'd0);
        end
        frame_start = 1'b1; mcu_valid = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        mcu_valid = 1'b0;
        drive_blocks(6, s);
        n_tests++;
        if (s !== 6) begin
            n_fail++; $display("FAIL midrst_refill_starts: got %0d expected 6", s);
        end
        tick;
        n_tests++;
        if (frame_done !== 1'b1) begin
            n_fail++; $display("FAIL midrst_frame_done: got %b expected 1", frame_done);
        end
        tick;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle: got busy=%b expected 0", busy);
        end
    endtask

`ifdef JPEG_SCHED_RESTART_EN
    task automatic test_restart;
        int cd, acd, n_start, n_mk, n_clr, n_fd;
        logic prev_req;
        cd = 0; acd = 0; n_start = 0; n_mk = 0; n_clr = 0; n_fd = 0; prev_req = 1'b0;
        frame_mcus = 16'd5; rst_interval = 16'd2; mcu_valid = 1'b1; ent_ready = 1'b1;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        for (int cyc = 0; cyc < 150; cyc++) begin
            dp_done = 1'b0;
            rst_marker_ack = 1'b0;
            if (cd > 0) begin cd--; if (cd == 0) dp_done = 1'b1; end
            if (acd > 0) begin acd--; if (acd == 0) rst_marker_ack = 1'b1; end
            if (dp_start === 1'b1) begin n_start++; cd = 1; end
            if (rst_marker_req === 1'b1 && !prev_req) begin
                n_tests++;
                if (rst_marker_idx !== 3'(n_mk) || n_start !== 6 * 2 * (n_mk + 1)) begin
                    n_fail++; $display("FAIL restart_marker%0d: got idx=%0d after %0d starts expected idx=%0d after %0d starts",
                                       n_mk, rst_marker_idx, n_start, n_mk, 12 * (n_mk + 1));
                end
                n_mk++;
                acd = 3;
            end
            prev_req = (rst_marker_req === 1'b1);
            if (dc_pred_clr === 1'b1) n_clr++;
            if (frame_done === 1'b1) n_fd++;
            tick;
        end
        dp_done = 1'b0; rst_marker_ack = 1'b0; mcu_valid = 1'b0; rst_interval = '0;
        n_tests++;
        if (n_mk !== 2) begin
            n_fail++; $display("FAIL restart_marker_count: got %0d expected 2", n_mk);
        end
        n_tests++;
        if (n_clr !== 3) begin
            n_fail++; $display("FAIL restart_dc_clr: got %0d expected 3", n_clr);
        end
        n_tests++;
        if (n_fd !== 1 || n_start !== 30) begin
            n_fail++; $display("FAIL restart_frame: got fd=%0d starts=%0d expected fd=1 starts=30", n_fd, n_start);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_nominal;
        tick;
        test_backpressure;
        tick;
        test_empty;
        test_spurious;
        tick;
        test_reset_mid_block;
        tick;
`ifdef JPEG_SCHED_RESTART_EN
        test_restart;
        tick;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_mcu_scheduler.md
# jpeg_mcu_scheduler

Sequences the blocks of each JPEG MCU through the shared DCT/quantizer datapath. It accepts whole MCUs from the block buffer and issues one start per 8x8 block. For each block it drives the component and quantization-table select, and paces issue against the entropy coder. It sits between the input block buffer and the DCT/quant/Huffman pipeline, and owns frame-level MCU counting and DC-predictor clearing.

## Interface
- MCU_BLOCKS, 6: blocks per MCU, legal range 3..6 (3 = 4:4:4, 4 = 4:2:2, 6 = 4:2:0).
- MCU_CNT_W, 16: width of the MCU count and restart interval.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  pulse; starts a frame (honoured only in IDLE).
- frame_mcus  in  MCU_CNT_W  MCUs in the frame; sampled with frame_start.
- mcu_valid  in  1  block buffer holds a complete MCU.
- mcu_ready  out  1  scheduler can take an MCU.
- ent_ready  in  1  entropy coder can accept one more block.
- dp_start  out  1  one-cycle datapath start.
- dp_blk_idx  out  3  block index within the MCU.
- dp_comp  out  2  component: 0 = Y, 1 = Cb, 2 = Cr.
- dp_qtab_sel  out  1  quant table: 0 = luma, 1 = chroma.
- dp_done  in  1  datapath finished the current block.
- dc_pred_clr  out  1  one-cycle clear of the DC predictors.
- frame_done  out  1  one-cycle end-of-frame pulse.
- busy  out  1  high whenever the state is not IDLE.
- Only with JPEG_SCHED_RESTART_EN:
  - rst_interval  in  MCU_CNT_W  MCUs between restart markers; 0 disables markers.
  - rst_marker_req  out  1  request insertion of a restart marker.
  - rst_marker_ack  in  1  marker has been inserted.
  - rst_marker_idx  out  3  RSTn index, 0..7.

## Operation
- States: IDLE, WAIT_MCU, ISSUE, RUN, NEXT, MARKER, FRAME_END.
- IDLE:
  - frame_start loads the MCU counter from frame_mcus and pulses dc_pred_clr in the following cycle.
  - Next state is WAIT_MCU, or FRAME_END if frame_mcus = 0.
- WAIT_MCU: mcu_ready = 1. When mcu_valid is also 1, the MCU is accepted, blk is set to 0 and the state goes to ISSUE.
- ISSUE: dp_start = ent_ready. On the first cycle with ent_ready = 1, the state goes to RUN.
- RUN:
  - dp_done with blk < MCU_BLOCKS-1: increment blk, go to ISSUE.
  - dp_done with blk = MCU_BLOCKS-1: go to NEXT.
- NEXT: decrement the MCU counter.
  - If the counter reaches 0, go to FRAME_END.
  - Otherwise go to MARKER when a restart is due, else to WAIT_MCU.
- FRAME_END: frame_done = 1 for one cycle, then IDLE.
- Component map:
  - blk < MCU_BLOCKS-2 gives Y.
  - blk = MCU_BLOCKS-2 gives Cb.
  - blk = MCU_BLOCKS-1 gives Cr.
  - dp_qtab_sel = (dp_comp != Y).
- dp_blk_idx, dp_comp and dp_qtab_sel are registered and held stable from entry to ISSUE until the state leaves RUN. They read 0 in all other states.
- Ignored events:
  - dp_done outside RUN.
  - frame_start outside IDLE.
  - mcu_valid outside WAIT_MCU.
- The MCU counter is decremented only in NEXT and never wraps below 0.

## Timing
- Reset value of every output is 0, including mcu_ready and busy. The state is IDLE.
- rst asserted in any state, including mid-block, returns the block to IDLE on that edge. Outputs read 0 in the next cycle, and any in-flight dp_done is dropped.
- Latencies:
  - frame_start to mcu_ready high: 1 cycle.
  - MCU accept to first possible dp_start: 1 cycle.
  - dp_done to next dp_start: 1 cycle when ent_ready = 1.
- dp_start and mcu_ready are decoded from registered state, plus ent_ready for dp_start.
- dp_done is honoured no earlier than the cycle after dp_start, so the minimum datapath latency is 1 cycle.
- frame_done follows the last dp_done after 2 cycles (NEXT, then FRAME_END).

## Configuration
- JPEG_SCHED_RESTART_EN defined:
  - The MARKER state and a restart counter are present.
  - In NEXT, a restart is due when rst_interval != 0, MCUs remain, and the MCU count since the last marker equals rst_interval.
  - In MARKER, rst_marker_req is held at 1 until rst_marker_ack. In the ack cycle: dc_pred_clr pulses the next cycle, rst_marker_idx increments mod 8, the counter clears, and the state goes to WAIT_MCU.
  - No marker is issued after the final MCU. rst_marker_idx resets to 0 at each frame_start.
- JPEG_SCHED_RESTART_EN undefined: the restart ports and MARKER state are absent, and NEXT never takes the restart branch.

## Structure
- jpeg_sched_pkg holds:
  - the state enum;
  - component encodings COMP_Y, COMP_CB, COMP_CR;
  - QTAB_LUMA and QTAB_CHROMA.
- Sub-module jpeg_rst_counter holds the restart-interval counter, the due flag and the marker index. It is instantiated only under JPEG_SCHED_RESTART_EN.

## Test plan
- Nominal 4:2:0 frame:
  - Stimulus: MCU_BLOCKS = 6, frame_mcus = 2, ent_ready = 1, dp_done 3 cycles after each dp_start.
  - Required: 12 dp_start pulses. dp_comp per MCU is 0,0,0,0,1,2 and dp_qtab_sel is 0,0,0,0,1,1. Exactly one frame_done, 2 cycles after the 12th dp_done.
- Entropy backpressure:
  - Stimulus: ent_ready = 0 for 5 cycles while in ISSUE at blk = 4.
  - Required: no dp_start during those cycles; dp_blk_idx = 4, dp_comp = 1 held; dp_start fires on the first ent_ready = 1 cycle.
- Empty frame:
  - Stimulus: frame_mcus = 0.
  - Required: dc_pred_clr and frame_done both pulse; no dp_start; mcu_ready stays 0; back in IDLE 2 cycles after frame_start.
- Restart markers (macro on):
  - Stimulus: rst_interval = 2, frame_mcus = 5, ack 3 cycles after each request.
  - Required: markers after MCU 2 (idx 0) and MCU 4 (idx 1); none after MCU 5; 3 dc_pred_clr pulses in total.
- Reset mid-block:
  - Stimulus: rst during RUN at blk = 3, then dp_done arrives in the next cycle.
  - Required: all outputs 0 and the late dp_done ignored. A following 1-MCU frame completes normally.
- Spurious events:
  - Stimulus: dp_done while in WAIT_MCU; frame_start while in RUN.
  - Required: no state change and no output pulses.
